// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the RAM and mem_port_arbiter.
// slave = arbiter view, master = requesters plus RAM (the environment).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  dbg_ack;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  stall;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, stall,
    output mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU MAR/MDR path vs. debug/loader port, fixed-latency
// access sequence, one-cycle ack, bounded starvation of the debug port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_port_arbiter_if.slave  bus
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..7");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
  end

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] MAX_W  = 4'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  state_e                state_q;
  logic [2:0]            wait_cnt_q;
  logic [3:0]            starve_cnt_q;
  logic                  we_q;
  logic                  owner_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_ack_q;
  logic                  dbg_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic                  grant_dbg_d;

  // Debug wins when alone, or when the CPU has used up its MAX_WAIT grants.
  always_comb begin
    grant_dbg_d = bus.dbg_req & (~bus.cpu_req | (starve_cnt_q == MAX_W));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.dbg_req) starve_cnt_q <= '0;
          if (bus.cpu_req || bus.dbg_req) begin
            owner_q     <= grant_dbg_d;
            we_q        <= grant_dbg_d ? bus.dbg_we    : bus.cpu_we;
            mem_we_q    <= grant_dbg_d ? bus.dbg_we    : bus.cpu_we;
            mem_addr_q  <= grant_dbg_d ? bus.dbg_addr  : bus.cpu_addr;
            mem_wdata_q <= grant_dbg_d ? bus.dbg_wdata : bus.cpu_wdata;
            mem_en_q    <= 1'b1;
            state_q     <= S_ACCESS;
            if (grant_dbg_d)
              starve_cnt_q <= '0;
            else if (bus.dbg_req && starve_cnt_q != MAX_W)
              starve_cnt_q <= starve_cnt_q + 4'd1;
          end
        end
        S_ACCESS: begin
          wait_cnt_q <= LAT_M1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q <= S_DONE;
            // mem_rdata is valid exactly on this edge; writes leave rdata alone.
            if (!we_q) begin
              if (owner_q) dbg_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
            if (owner_q) dbg_ack_q <= 1'b1;
            else         cpu_ack_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.stall     = bus.cpu_req & ~cpu_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner     = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port program/data RAM between the CPU control unit's MAR/MDR memory path and a debug/program-loader port. Each granted request runs through a fixed-latency access sequence, and the requester gets a one-cycle acknowledge with registered read data. A bounded-starvation priority rule keeps a loader from being locked out by a running program. The block sits between the control unit / MDR and the RAM; the control unit holds its present state while the stall output is high.

## Interface
- ADDR_WIDTH, 9, word address width (512-word RAM)
- DATA_WIDTH, 32, data word width
- MEM_LATENCY, 1, cycles from RAM enable to valid mem_rdata; legal range 1..7, anything else is an elaboration error
- MAX_WAIT, 4, consecutive CPU grants allowed while dbg_req is pending, legal range 1..15
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address (from MAR)
- cpu_wdata  in  DATA_WIDTH  write data (from MDR)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  registered read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug port, same rules as the CPU port
- dbg_ack  out  1  debug port completion pulse
- dbg_rdata  out  DATA_WIDTH  debug port registered read data
- stall  out  1  cpu_req & ~cpu_ack (combinational); the control unit freezes while it is high
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data
- owner  out  1  port latched by the current or last grant (0 = CPU, 1 = debug)

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner and latch its we/addr/wdata into the mem_* registers and owner, then go to ACCESS.
- **Arbitration (in IDLE only)**
  - Only one request high: that port wins.
  - Both high: CPU wins unless starve_cnt == MAX_WAIT, in which case debug wins.
- **starve_cnt**
  - Increments on a CPU grant while dbg_req is high, saturating at MAX_WAIT.
  - Clears on a debug grant.
  - Clears in any IDLE cycle where dbg_req is low.
- **ACCESS** lasts exactly one cycle.
  - mem_en = 1.
  - mem_we = the latched we.
  - Then go to WAIT with wait_cnt = MEM_LATENCY-1.
- **WAIT**
  - mem_en and mem_we are 0.
  - Decrement wait_cnt each cycle; leave WAIT when it is 0.
  - At the exiting edge, if the access was a read, capture mem_rdata into the owner's rdata register.
  - Writes leave both rdata registers unchanged.
- **DONE**
  - Pulse the owner's ack for one cycle, then return to IDLE.
  - Requests are not sampled in DONE.
- **Requester rules**
  - Hold req and all fields stable until ack.
  - Deassert req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE counts as a new request.
- **Early request drop:** if req drops before ack (illegal), the access still completes and ack still pulses.
- mem_addr and mem_wdata hold their last latched values while idle. mem_we is never 1 outside ACCESS.

## Timing
- Reset values:
  - FSM = IDLE.
  - All acks, mem_en and mem_we = 0.
  - cpu_rdata, dbg_rdata, mem_addr, mem_wdata = 0.
  - owner = 0, starve_cnt = 0, wait_cnt = 0.
- Latency: request high in IDLE cycle t, then:
  - ACCESS at t+1.
  - WAIT from t+2 to t+1+MEM_LATENCY.
  - ack at t+2+MEM_LATENCY.
  - Next possible grant at t+3+MEM_LATENCY.
  - With MEM_LATENCY=1: ack at t+3, so a back-to-back access takes 4 cycles.
- Read data: cpu_rdata/dbg_rdata are valid in the ack cycle and held until the next read by that port.
- Simultaneous requests:
  - A single-cycle grant decision in IDLE.
  - The loser's req stays high and is granted at its next turn.
- Reset asserted mid-operation:
  - Immediate return to IDLE; the pending ack is never issued.
  - A write is committed only if its ACCESS edge completed before reset.
  - Requesters must reissue.
- Address values pass through unmodified; there is no wrap logic.

## Test plan
- **Single CPU read:**
  - Preload RAM[0x010] = 0x12345678.
  - Raise cpu_req with we=0, addr=0x010 at cycle 5.
  - Required: mem_en only at cycle 6, cpu_ack at cycle 8, cpu_rdata = 0x12345678, stall high during cycles 5–7.
- **Debug write then CPU read:**
  - dbg writes 0xDEADBEEF to 0x1FF.
  - CPU then reads 0x1FF.
  - Required: mem_we = 1 for exactly one cycle; CPU receives 0xDEADBEEF; dbg_rdata unchanged (0).
- **Contention:**
  - cpu_req and dbg_req are held continuously, with MAX_WAIT = 4.
  - Required: grant order CPU, CPU, CPU, CPU, DBG, CPU…; starve_cnt returns to 0 after the DBG grant.
- **Back-to-back requests:**
  - CPU reissues a request in the cycle after each ack.
  - Required: a grant every 4 cycles; no double ack; no request serviced in DONE.
- **Reset mid-access:**
  - Drop reset during WAIT of a CPU read.
  - Required: all outputs at reset values in the same cycle; no cpu_ack; the next request completes normally.
- **Latency parameter:**
  - MEM_LATENCY = 3, CPU read issued at cycle t.
  - Required: ack at t+5; data captured from mem_rdata at the end of cycle t+4.
